// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-side companion of the gshare predictor.
// Keeps an in-order FIFO of fetch-time predictions. When EX resolves an
// instruction, the unit retires the oldest entry and drives the predictor
// update port. On a mispredict it sends a one-cycle PC redirect, clears the
// FIFO and holds fetch in FLUSH for FLUSH_CYCLES cycles.
// Optional build macro: BRU_PERF_CNT_EN adds saturating perf counters
// (perfBranches, perfMispredicts, perfFalseHits).
module branch_resolve_unit #(
  parameter int DEPTH        = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetchValid,
  input  logic [31:0]            fetchPc,
  input  logic                   fetchPredTaken,
  input  logic [31:0]            fetchPredTarget,
  output logic                   fetchReady,
  input  logic                   exValid,
  input  logic                   exBranch,
  input  logic                   exTaken,
  input  logic [31:0]            exTarget,
  output logic                   updBranch,
  output logic                   updTaken,
  output logic [31:0]            updPc,
  output logic [31:0]            updTarget,
  output logic                   redirectValid,
  output logic [31:0]            redirectPc,
  output logic                   flush,
  output logic [$clog2(DEPTH):0] qCount
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]   perfBranches,
  output logic [CNT_WIDTH-1:0]   perfMispredicts,
  output logic [CNT_WIDTH-1:0]   perfFalseHits
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  // Reject parameter sets the pointer and counter logic cannot handle.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FLUSH_CYCLES < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("branch_resolve_unit: illegal parameter set");
  end

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t        r_state, w_stateNext;
  logic [FW-1:0] r_flushCnt, w_flushCntNext;

  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;
  logic [31:0]   r_pc        [DEPTH];
  logic          r_predTaken [DEPTH];
  logic [31:0]   r_predTgt   [DEPTH];

  logic          w_push, w_pop, w_mispredict, w_falseHit;
  logic [31:0]   w_headPc, w_headTgt, w_correctPc;
  logic          w_headTaken;

  assign w_headPc    = r_pc[r_head];
  assign w_headTaken = r_predTaken[r_head];
  assign w_headTgt   = r_predTgt[r_head];

  // EX only retires in RUN and only if something is in flight.
  assign w_pop      = exValid && (r_state == S_RUN) && (r_count != '0);
  assign w_push     = fetchValid && fetchReady;
  assign w_falseHit = !exBranch && w_headTaken;

  assign w_mispredict = w_pop && (
      (exBranch && (w_headTaken != exTaken)) ||
      (exBranch && w_headTaken && exTaken && (w_headTgt != exTarget)) ||
      w_falseHit);

  assign w_correctPc = (exBranch && exTaken) ? exTarget : (w_headPc + 32'd4);

  assign qCount = r_count;

  // FSM state register; flush down-counter lives alongside it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_RUN;
      r_flushCnt <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_flushCnt <= w_flushCntNext;
    end
  end

  // Next-state and fetch-side handshake outputs.
  always_comb begin
    w_stateNext    = r_state;
    w_flushCntNext = r_flushCnt;
    fetchReady     = 1'b0;
    flush          = 1'b0;
    case (r_state)
      S_RUN: begin
        fetchReady = (r_count != (AW+1)'(DEPTH));
        if (w_mispredict) begin
          w_stateNext    = S_FLUSH;
          w_flushCntNext = FW'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (r_flushCnt == '0) w_stateNext = S_RUN;
        else                  w_flushCntNext = r_flushCnt - 1'b1;
      end
      default: w_stateNext = S_RUN;
    endcase
  end

  // FIFO pointers and occupancy; a mispredict wipes everything, including
  // a push arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_mispredict) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written so no reset.
  always_ff @(posedge clk) begin
    if (w_push && !w_mispredict) begin
      r_pc[r_tail]        <= fetchPc;
      r_predTaken[r_tail] <= fetchPredTaken;
      r_predTgt[r_tail]   <= fetchPredTarget;
    end
  end

  // Registered predictor update and redirect; idle values are zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      updBranch     <= 1'b0;
      updTaken      <= 1'b0;
      updPc         <= '0;
      updTarget     <= '0;
      redirectValid <= 1'b0;
      redirectPc    <= '0;
    end else begin
      updBranch     <= w_pop && exBranch;
      updTaken      <= w_pop && exBranch && exTaken;
      updPc         <= (w_pop && exBranch) ? w_headPc : '0;
      updTarget     <= (w_pop && exBranch) ? exTarget : '0;
      redirectValid <= w_mispredict;
      redirectPc    <= w_mispredict ? w_correctPc : '0;
    end
  end

`ifdef BRU_PERF_CNT_EN
  // Saturating event counters, bumped on the edge that raises the pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perfBranches    <= '0;
      perfMispredicts <= '0;
      perfFalseHits   <= '0;
    end else begin
      if (w_pop && exBranch && (perfBranches != '1))
        perfBranches <= perfBranches + 1'b1;
      if (w_mispredict && (perfMispredicts != '1))
        perfMispredicts <= perfMispredicts + 1'b1;
      if (w_pop && w_falseHit && (perfFalseHits != '1))
        perfFalseHits <= perfFalseHits + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand-written
// fill/wrap sequence, then random traffic against a queue-based model.
module tb_branch_resolve_unit;

  localparam int DEPTH = 8;
  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchValid, fetchPredTaken, fetchReady;
  logic [31:0] fetchPc, fetchPredTarget;
  logic        exValid, exBranch, exTaken;
  logic [31:0] exTarget;
  logic        updBranch, updTaken, redirectValid, flush;
  logic [31:0] updPc, updTarget, redirectPc;
  logic [3:0]  qCount;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perfBranches, perfMispredicts, perfFalseHits;
`endif

  branch_resolve_unit dut (
    .clk(clk), .rst(rst),
    .fetchValid(fetchValid), .fetchPc(fetchPc), .fetchPredTaken(fetchPredTaken),
    .fetchPredTarget(fetchPredTarget), .fetchReady(fetchReady),
    .exValid(exValid), .exBranch(exBranch), .exTaken(exTaken), .exTarget(exTarget),
    .updBranch(updBranch), .updTaken(updTaken), .updPc(updPc), .updTarget(updTarget),
    .redirectValid(redirectValid), .redirectPc(redirectPc), .flush(flush), .qCount(qCount)
`ifdef BRU_PERF_CNT_EN
    , .perfBranches(perfBranches), .perfMispredicts(perfMispredicts), .perfFalseHits(perfFalseHits)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    bit          pt;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  int          flLeft;
  bit          m_ub, m_ut, m_rv;
  logic [31:0] m_upc, m_utgt, m_rpc;
  int          m_pb, m_pm, m_pf;

  task automatic model(input bit rn, input bit fv, input logic [31:0] fpc, input bit fpt,
                       input logic [31:0] ftgt, input bit ev, input bit eb, input bit et,
                       input logic [31:0] etgt);
    ent_t h;
    bit inFl, rdy, pop, mis;
    if (!rn) begin
      mq.delete();
      flLeft = 0;
      m_ub = 0; m_ut = 0; m_upc = 0; m_utgt = 0; m_rv = 0; m_rpc = 0;
      m_pb = 0; m_pm = 0; m_pf = 0;
      return;
    end
    inFl = (flLeft > 0);
    rdy  = !inFl && (mq.size() < DEPTH);
    pop  = !inFl && ev && (mq.size() > 0);
    h.pc = 0; h.pt = 0; h.tgt = 0;
    if (pop) h = mq[0];
    if (!pop)    mis = 0;
    else if (eb) mis = (h.pt != et) || (et && (h.tgt != etgt));
    else         mis = h.pt;
    m_ub   = pop && eb;
    m_ut   = pop && eb && et;
    m_upc  = (pop && eb) ? h.pc : 32'h0;
    m_utgt = (pop && eb) ? etgt : 32'h0;
    m_rv   = mis;
    m_rpc  = !mis ? 32'h0 : ((eb && et) ? etgt : h.pc + 32'd4);
    if (pop && eb) m_pb++;
    if (mis) m_pm++;
    if (mis && !eb) m_pf++;
    if (inFl) flLeft--;
    if (mis) begin
      mq.delete();
      flLeft = FLUSH_CYCLES;
    end else begin
      if (pop) void'(mq.pop_front());
      if (fv && rdy) begin
        h.pc = fpc; h.pt = fpt; h.tgt = ftgt;
        mq.push_back(h);
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_exp(input string tag, input bit ub, input bit ut, input logic [31:0] upc,
                         input logic [31:0] utgt, input bit rv, input logic [31:0] rpc,
                         input bit fl, input bit rdy, input int q);
    chk({tag, ".updBranch"},     32'(updBranch),     32'(ub));
    chk({tag, ".updTaken"},      32'(updTaken),      32'(ut));
    chk({tag, ".updPc"},         updPc,              upc);
    chk({tag, ".updTarget"},     updTarget,          utgt);
    chk({tag, ".redirectValid"}, 32'(redirectValid), 32'(rv));
    chk({tag, ".redirectPc"},    redirectPc,         rpc);
    chk({tag, ".flush"},         32'(flush),         32'(fl));
    chk({tag, ".fetchReady"},    32'(fetchReady),    32'(rdy));
    chk({tag, ".qCount"},        32'(qCount),        32'(q));
  endtask

  task automatic cmp_model(input string tag);
    cmp_exp(tag, m_ub, m_ut, m_upc, m_utgt, m_rv, m_rpc, flLeft > 0,
            (flLeft == 0) && (mq.size() < DEPTH), mq.size());
  endtask

  // One clock: drive at negedge, advance model, sample 1 time unit after posedge.
  task automatic step(input bit rn, input bit fv, input logic [31:0] fpc, input bit fpt,
                      input logic [31:0] ftgt, input bit ev, input bit eb, input bit et,
                      input logic [31:0] etgt);
    @(negedge clk);
    rst = rn; fetchValid = fv; fetchPc = fpc; fetchPredTaken = fpt; fetchPredTarget = ftgt;
    exValid = ev; exBranch = eb; exTaken = et; exTarget = etgt;
    model(rn, fv, fpc, fpt, ftgt, ev, eb, et, etgt);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rn, fv; logic [31:0] fpc; bit fpt; logic [31:0] ftgt;
    bit ev, eb, et; logic [31:0] etgt;
    bit ub, ut; logic [31:0] upc, utgt; bit rv; logic [31:0] rpc;
    bit fl, rdy; int q;
  } vec_t;

  function automatic vec_t mk(bit rn, bit fv, logic [31:0] fpc, bit fpt, logic [31:0] ftgt,
                              bit ev, bit eb, bit et, logic [31:0] etgt,
                              bit ub, bit ut, logic [31:0] upc, logic [31:0] utgt,
                              bit rv, logic [31:0] rpc, bit fl, bit rdy, int q);
    vec_t v;
    v.rn = rn; v.fv = fv; v.fpc = fpc; v.fpt = fpt; v.ftgt = ftgt;
    v.ev = ev; v.eb = eb; v.et = et; v.etgt = etgt;
    v.ub = ub; v.ut = ut; v.upc = upc; v.utgt = utgt; v.rv = rv; v.rpc = rpc;
    v.fl = fl; v.rdy = rdy; v.q = q;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    bit rn, fv, fpt, ev, eb, et;
    logic [31:0] fpc, ftgt, etgt;
    int evp;

    rst = 0; fetchValid = 0; fetchPc = 0; fetchPredTaken = 0; fetchPredTarget = 0;
    exValid = 0; exBranch = 0; exTaken = 0; exTarget = 0;

    //            rn fv fpc           fpt ftgt    ev eb et etgt      ub ut upc      utgt    rv rpc     fl rdy q
    tbl.push_back(mk(0, 0, 0,            0, 0,      0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      0, 1, 0));
    tbl.push_back(mk(1, 1, 'h100,        0, 0,      0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      0, 1, 1));
    tbl.push_back(mk(1, 0, 0,            0, 0,      1, 1, 0, 'h104,    1, 0, 'h100,   'h104,  0, 0,      0, 1, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      0, 1, 0));
    tbl.push_back(mk(1, 1, 'h200,        0, 0,      0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      0, 1, 1));
    tbl.push_back(mk(1, 1, 'h999,        0, 0,      1, 1, 1, 'h400,    1, 1, 'h200,   'h400,  1, 'h400,  1, 0, 0));
    tbl.push_back(mk(1, 1, 'h998,        0, 0,      1, 1, 0, 0,        0, 0, 0,       0,      0, 0,      1, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      0, 1, 0));
    tbl.push_back(mk(1, 1, 'h300,        1, 'h500,  0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      0, 1, 1));
    tbl.push_back(mk(1, 0, 0,            0, 0,      1, 1, 1, 'h600,    1, 1, 'h300,   'h600,  1, 'h600,  1, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      1, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      0, 1, 0));
    tbl.push_back(mk(1, 1, 'h10,         1, 'h80,   0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      0, 1, 1));
    tbl.push_back(mk(1, 0, 0,            0, 0,      1, 0, 0, 'h1234,   0, 0, 0,       0,      1, 'h14,   1, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      1, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,      0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      0, 1, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      1, 1, 1, 'h55,     0, 0, 0,       0,      0, 0,      0, 1, 0));
    tbl.push_back(mk(1, 1, 'h40,         1, 'h80,   0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      0, 1, 1));
    tbl.push_back(mk(1, 0, 0,            0, 0,      1, 1, 1, 'h80,     1, 1, 'h40,    'h80,   0, 0,      0, 1, 0));
    tbl.push_back(mk(1, 1, 'hFFFFFFFC,   1, 'h8,    0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      0, 1, 1));
    tbl.push_back(mk(1, 0, 0,            0, 0,      1, 0, 1, 'h700,    0, 0, 0,       0,      1, 'h0,    1, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      1, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0, 0,        0, 0, 0,       0,      0, 0,      0, 1, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rn, tbl[i].fv, tbl[i].fpc, tbl[i].fpt, tbl[i].ftgt,
           tbl[i].ev, tbl[i].eb, tbl[i].et, tbl[i].etgt);
      cmp_exp($sformatf("tbl%0d", i), tbl[i].ub, tbl[i].ut, tbl[i].upc, tbl[i].utgt,
              tbl[i].rv, tbl[i].rpc, tbl[i].fl, tbl[i].rdy, tbl[i].q);
    end

    // ---------------- fill, overflow attempt, wrap-around ----------------
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
      chk($sformatf("fill%0d.qCount", i), 32'(qCount), 32'(i + 1));
    end
    chk("full.fetchReady", 32'(fetchReady), 32'h0);
    step(1, 1, 32'h2000, 0, 0, 0, 0, 0, 0);
    chk("full_push_dropped.qCount", 32'(qCount), 32'(DEPTH));
    step(1, 0, 0, 0, 0, 1, 1, 0, 32'h0);
    chk("first_pop.updPc", updPc, 32'h1000);
    chk("first_pop.qCount", 32'(qCount), 32'(DEPTH - 1));
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 32'h3000 + 32'(4 * i), 0, 0, 1, 1, 0, 32'h0);
      chk($sformatf("wrap%0d.updPc", i), updPc,
          (i < 7) ? 32'h1004 + 32'(4 * i) : 32'h3000 + 32'(4 * (i - 7)));
      chk($sformatf("wrap%0d.qCount", i), 32'(qCount), 32'(DEPTH - 1));
      cmp_model($sformatf("wrap%0d", i));
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 0, 0, 1, 1, 0, 32'h0);
      cmp_model($sformatf("drain%0d", i));
    end

    // ---------------- random traffic vs model ----------------
    for (int c = 0; c < 3000; c++) begin
      evp  = ((c / 500) % 3 == 0) ? 2 : (((c / 500) % 3 == 1) ? 5 : 8);
      rn   = ($urandom_range(0, 299) != 0);
      fv   = ($urandom_range(0, 9) < 6);
      fpc  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFF_FFFC);
      fpt  = $urandom_range(0, 1) == 1;
      ftgt = 32'h100 + 32'($urandom_range(0, 3)) * 32'h40;
      ev   = ($urandom_range(0, 9) < evp);
      eb   = ($urandom_range(0, 9) < 7);
      et   = $urandom_range(0, 1) == 1;
      etgt = 32'h100 + 32'($urandom_range(0, 3)) * 32'h40;
      step(rn, fv, fpc, fpt, ftgt, ev, eb, et, etgt);
      cmp_model($sformatf("rnd%0d", c));
    end

`ifdef BRU_PERF_CNT_EN
    chk("perfBranches",    perfBranches,    32'(m_pb));
    chk("perfMispredicts", perfMispredicts, 32'(m_pm));
    chk("perfFalseHits",   perfFalseHits,   32'(m_pf));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-side counterpart to the gshare predictor.
- Records every fetch-time prediction in an in-order FIFO. Retires entries as EX resolves instructions.
- Produces the predictor update port (branch, taken, pc, target) and the front-end redirect/flush on a mispredict.
- Sits between the fetch stage, the predictor's update inputs and the PC mux.

Parameters:
- DEPTH, 8: in-flight prediction FIFO entries; power of two, at least 2.
- FLUSH_CYCLES, 2: cycles fetch stays stalled after a redirect; at least 1.
- CNT_WIDTH, 32: width of the performance counters; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- fetchValid  in  1  fetch presents an instruction.
- fetchPc  in  32  PC of the fetched instruction.
- fetchPredTaken  in  1  predictor hit (predicted taken).
- fetchPredTarget  in  32  predicted target.
- fetchReady  out  1  FIFO can accept this cycle.
- exValid  in  1  EX resolves the oldest in-flight instruction.
- exBranch  in  1  resolved instruction is a branch/jump.
- exTaken  in  1  actual direction.
- exTarget  in  32  actual target.
- updBranch  out  1  predictor update strobe (drives the predictor's exBranch).
- updTaken  out  1  drives the predictor's exTaken.
- updPc  out  32  drives the predictor's exPc.
- updTarget  out  32  drives the predictor's exTarget.
- redirectValid  out  1  one-cycle PC redirect pulse.
- redirectPc  out  32  correct next PC.
- flush  out  1  high during the whole FLUSH state.
- qCount  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0 at a clk edge):
  - FIFO empty, pointers 0, qCount=0.
  - State RUN.
  - All upd* = 0, redirectValid=0, redirectPc=0, flush=0.
  - fetchReady=1 from the first cycle after reset deasserts.
  - Reset mid-flush aborts FLUSH immediately.
- States:
  - RUN: fetchReady = (qCount != DEPTH).
  - FLUSH: fetchReady=0, flush=1, exValid is ignored, down-counter runs.
  - FLUSH -> RUN when the counter reaches 0, after exactly FLUSH_CYCLES cycles.
- Push: fetchValid && fetchReady writes {fetchPc, fetchPredTaken, fetchPredTarget} at the tail.
- Pop:
  - Occurs on exValid in RUN with qCount>0.
  - exValid on an empty FIFO is ignored: no pop, no outputs.
- Simultaneous push and pop: qCount unchanged; wrap-around by modulo-DEPTH pointers.
- Mispredict on pop when any of the following holds:
  - exBranch && (predTaken != exTaken);
  - exBranch && predTaken && exTaken && (predTarget != exTarget);
  - !exBranch && predTaken (false hit).
- Correct PC: exBranch && exTaken ? exTarget : headPc+4 (32-bit wrap).
- Update (registered, one cycle after the pop):
  - For exBranch: updBranch=1 for exactly one cycle, updTaken=exTaken, updPc=headPc, updTarget=exTarget.
  - A false hit (non-branch) does not pulse updBranch.
- Mispredict (registered, one cycle after the pop):
  - redirectValid=1 for one cycle with redirectPc = correct PC.
  - FIFO cleared, qCount=0.
  - Any push in the mispredict cycle is dropped.
  - Enter FLUSH; flush rises in the same cycle as redirectValid.
- A correct prediction produces no redirect.
- When fetchReady=0 (full or FLUSH), fetchValid has no effect.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- When defined, adds three outputs, each CNT_WIDTH wide:
  - perfBranches: counts updBranch pulses.
  - perfMispredicts: counts redirectValid pulses.
  - perfFalseHits: counts false-hit redirects.
- All three reset to 0 and saturate at all-ones.
- When undefined, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Push PC 0x100 with predTaken=0, then exValid, exBranch=1, exTaken=0 -> next cycle updBranch=1, updTaken=0, updPc=0x100, no redirect, qCount back to 0.
- Push PC 0x200 with predTaken=0, then resolve exBranch=1, exTaken=1, exTarget=0x400 -> redirectValid=1, redirectPc=0x400, updTaken=1; flush=1 for 2 cycles with fetchReady=0; qCount=0.
- Push 0x300 with predTaken=1, predTarget=0x500, then resolve taken with exTarget=0x600 -> redirectPc=0x600 (target mismatch).
- Push 0x10 with predTaken=1, then resolve exBranch=0 -> redirectPc=0x14, updBranch stays 0.
- Push 8 entries without popping -> fetchReady=0 and qCount=8. Then push and pop in the same cycle on a non-full FIFO -> qCount unchanged; pointers wrap and entries pop in order.
- exValid on an empty FIFO -> no outputs. Assert rst=0 during FLUSH -> next cycle state RUN, fetchReady=1, all outputs 0.
